// File: rtl/grid_div_arbiter_pkg.sv
// Shared constants and response tags for the grid divider arbiter.
// Used by grid_div_arbiter and twenty_division.
package grid_div_arbiter_pkg;
   localparam int CELL      = 20;
   localparam int MAX_COORD = 400;
   localparam int REM_W     = 5;

   typedef enum logic {
      TAG_A = 1'b0,
      TAG_B = 1'b1
   } tag_t;
endpackage

// File: rtl/grid_div_arbiter_twenty_division.sv
// Combinational pixel-to-cell divider by 20 over the playfield.
// Exact multiples of 20 map to the lower cell; beyond MAX_COORD yields 0.
module twenty_division #(
   parameter int DW = 10
) (
   input  logic [DW-1:0] dividend,
   output logic [DW-1:0] quot
);
   import grid_div_arbiter_pkg::*;

   localparam int NCELL = MAX_COORD / CELL;

   // Count the cell boundaries strictly below the coordinate.
   always_comb begin
      quot = '0;
      if (dividend <= DW'(MAX_COORD)) begin
         for (int k = 1; k < NCELL; k++) begin
            if (dividend > DW'(k * CELL)) quot = quot + DW'(1);
         end
      end
   end
endmodule

// File: rtl/grid_div_arbiter.sv
// Two-port arbiter sharing one twenty_division unit, two-stage pipeline.
// GRID_DIV_RR_EN selects strict round-robin instead of A-priority.
module grid_div_arbiter #(
   parameter int DW           = 10,
   parameter int CELL         = 20,
   parameter int MAX_COORD    = 400,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   a_req_valid,
   output logic                                   a_req_ready,
   input  logic [DW-1:0]                          a_dividend,
   output logic                                   a_resp_valid,
   input  logic                                   a_resp_ready,
   input  logic                                   b_req_valid,
   output logic                                   b_req_ready,
   input  logic [DW-1:0]                          b_dividend,
   output logic                                   b_resp_valid,
   input  logic                                   b_resp_ready,
   output logic [DW-1:0]                          resp_quot,
   output logic [grid_div_arbiter_pkg::REM_W-1:0] resp_rem,
   output logic                                   resp_oor
);
   import grid_div_arbiter_pkg::*;

   logic             run;
   logic             s1_valid;
   tag_t             s1_tag;
   logic [DW-1:0]    s1_dividend;
   logic             s2_valid;
   tag_t             s2_tag;
   logic [DW-1:0]    s2_quot;
   logic [REM_W-1:0] s2_rem;
   logic             s2_oor;

   logic             s2_free;
   logic             s1_free;
   logic             grant_a;
   logic             grant_b;
   logic [DW-1:0]    div_quot;
   logic [DW-1:0]    quot;
   logic [DW-1:0]    prod;
   logic [REM_W-1:0] rem;
   logic             oor;

   assign s2_free = !s2_valid ||
                    (s2_tag == TAG_A ? a_resp_ready : b_resp_ready);
   assign s1_free = !s1_valid || s2_free;

`ifdef GRID_DIV_RR_EN
   tag_t last;

   assign grant_a = a_req_valid && (!b_req_valid || last == TAG_B);
   assign grant_b = b_req_valid && (!a_req_valid || last == TAG_A);

   // Pointer starts at B so A wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= TAG_B;
      end else if (a_req_ready) begin
         last <= TAG_A;
      end else if (b_req_ready) begin
         last <= TAG_B;
      end
   end
`else
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt;

   assign grant_b = b_req_valid &&
                    (!a_req_valid || starve_cnt == SW'(STARVE_LIMIT));
   assign grant_a = a_req_valid && !grant_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!b_req_valid || b_req_ready) begin
         starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end
`endif

   // run keeps both readies low while reset is held.
   assign a_req_ready = run && s1_free && grant_a;
   assign b_req_ready = run && s1_free && grant_b;

   twenty_division #(
      .DW (DW)
   ) u_div (
      .dividend (s1_dividend),
      .quot     (div_quot)
   );

   assign oor  = s1_dividend > DW'(MAX_COORD);
   assign quot = oor ? '0 : div_quot;
   assign prod = quot * DW'(CELL);
   assign rem  = oor ? '0 : REM_W'(s1_dividend - prod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run         <= 1'b0;
         s1_valid    <= 1'b0;
         s1_tag      <= TAG_A;
         s1_dividend <= '0;
         s2_valid    <= 1'b0;
         s2_tag      <= TAG_A;
         s2_quot     <= '0;
         s2_rem      <= '0;
         s2_oor      <= 1'b0;
      end else begin
         run <= 1'b1;
         if (s1_free) begin
            s1_valid <= a_req_ready || b_req_ready;
            s1_tag   <= b_req_ready ? TAG_B : TAG_A;
            if (b_req_ready) begin
               s1_dividend <= b_dividend;
            end else if (a_req_ready) begin
               s1_dividend <= a_dividend;
            end
         end
         if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_tag  <= s1_tag;
               s2_quot <= quot;
               s2_rem  <= rem;
               s2_oor  <= oor;
            end
         end
      end
   end

   assign a_resp_valid = s2_valid && s2_tag == TAG_A;
   assign b_resp_valid = s2_valid && s2_tag == TAG_B;
   assign resp_quot    = s2_quot;
   assign resp_rem     = s2_rem;
   assign resp_oor     = s2_oor;
endmodule

// File: tb/tb_grid_div_arbiter.sv
// Directed and random bench for grid_div_arbiter with a reference model.
// Build with GRID_DIV_RR_EN to match the round-robin arbitration.
module tb_grid_div_arbiter;
   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req_valid;
   logic          a_req_ready;
   logic [DW-1:0] a_dividend;
   logic          a_resp_valid;
   logic          a_resp_ready;
   logic          b_req_valid;
   logic          b_req_ready;
   logic [DW-1:0] b_dividend;
   logic          b_resp_valid;
   logic          b_resp_ready;
   logic [DW-1:0] resp_quot;
   logic [4:0]    resp_rem;
   logic          resp_oor;

   always #5 clk = ~clk;

   grid_div_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_req_valid  (a_req_valid),
      .a_req_ready  (a_req_ready),
      .a_dividend   (a_dividend),
      .a_resp_valid (a_resp_valid),
      .a_resp_ready (a_resp_ready),
      .b_req_valid  (b_req_valid),
      .b_req_ready  (b_req_ready),
      .b_dividend   (b_dividend),
      .b_resp_valid (b_resp_valid),
      .b_resp_ready (b_resp_ready),
      .resp_quot    (resp_quot),
      .resp_rem     (resp_rem),
      .resp_oor     (resp_oor)
   );

   typedef struct {
      logic          tag;
      logic [DW-1:0] d;
   } req_t;

   req_t sb[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   b_wait = 0;
   logic last_b = 1'b1;
   logic acc_a  = 1'b0;
   logic acc_b  = 1'b0;

   function automatic int ref_quot(int d);
      if (d > 400 || d == 0) return 0;
      return (d - 1) / 20;
   endfunction

   function automatic int ref_rem(int d);
      if (d > 400) return 0;
      return d - 20 * ref_quot(d);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, update model, realign after posedge.
   task automatic tick();
      req_t       r;
      logic [1:0] exp_g;
      @(negedge clk);
      acc_a = a_req_valid && a_req_ready;
      acc_b = b_req_valid && b_req_ready;
      check("one_ready", 32'(a_req_ready && b_req_ready), 0);
`ifdef GRID_DIV_RR_EN
      if (a_req_valid && (!b_req_valid || last_b)) exp_g = 2'b10;
      else if (b_req_valid) exp_g = 2'b01;
      else exp_g = 2'b00;
`else
      if (b_req_valid && (!a_req_valid || b_wait == 4)) exp_g = 2'b01;
      else if (a_req_valid) exp_g = 2'b10;
      else exp_g = 2'b00;
`endif
      if (a_req_ready || b_req_ready)
         check("grant", 32'({a_req_ready, b_req_ready}), 32'(exp_g));
      if (acc_a) begin
         r.tag = 1'b0;
         r.d   = a_dividend;
         sb.push_back(r);
         last_b = 1'b0;
      end
      if (acc_b) begin
         r.tag = 1'b1;
         r.d   = b_dividend;
         sb.push_back(r);
         last_b = 1'b1;
      end
      if (!b_req_valid || acc_b) b_wait = 0;
      else if (b_wait < 4) b_wait++;
      check("resp_both", 32'(a_resp_valid && b_resp_valid), 0);
      if ((a_resp_valid && a_resp_ready) ||
          (b_resp_valid && b_resp_ready)) begin
         check("resp_pending", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            r = sb.pop_front();
            check("resp_tag", 32'(b_resp_valid), 32'(r.tag));
            check("resp_quot", 32'(resp_quot), ref_quot(int'(r.d)));
            check("resp_rem", 32'(resp_rem), ref_rem(int'(r.d)));
            check("resp_oor", 32'(resp_oor), 32'(r.d > 400));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int bvals[4];
      bvals = '{20, 21, 400, 401};

      rst_n        = 1'b0;
      a_req_valid  = 1'b1;
      b_req_valid  = 1'b1;
      a_dividend   = 10'd45;
      b_dividend   = 10'd0;
      a_resp_ready = 1'b1;
      b_resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_rdy", 32'(a_req_ready), 0);
      check("rst_b_rdy", 32'(b_req_ready), 0);
      check("rst_a_rv", 32'(a_resp_valid), 0);
      check("rst_b_rv", 32'(b_resp_valid), 0);
      check("rst_quot", 32'(resp_quot), 0);
      check("rst_rem", 32'(resp_rem), 0);
      check("rst_oor", 32'(resp_oor), 0);
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();

      // single request
      a_dividend  = 10'd45;
      a_req_valid = 1'b1;
      acc_a = 1'b0;
      n = 0;
      while (!acc_a && n < 10) begin
         tick();
         n++;
      end
      check("single_acc", 32'(acc_a), 1);
      a_req_valid = 1'b0;
      check("single_lat1", 32'(a_resp_valid), 0);
      tick();
      check("single_lat2", 32'(a_resp_valid), 1);
      check("single_quot", 32'(resp_quot), ref_quot(45));
      check("single_rem", 32'(resp_rem), ref_rem(45));
      check("single_oor", 32'(resp_oor), 0);
      tick();
      tick();

      // boundary values back-to-back
      a_req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_dividend = DW'(bvals[i]);
         #1;
         check("bnd_rdy", 32'(a_req_ready), 1);
         if (i >= 2) check("bnd_rv", 32'(a_resp_valid), 1);
         tick();
      end
      a_req_valid = 1'b0;
      check("bnd_rv", 32'(a_resp_valid), 1);
      tick();
      check("bnd_rv", 32'(a_resp_valid), 1);
      tick();
      check("bnd_end", 32'(a_resp_valid), 0);
      tick();

`ifdef GRID_DIV_RR_EN
      a_dividend  = 10'd10;
      b_dividend  = 10'd300;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      #1;
      for (int c = 0; c < 6; c++) begin
         check("rr_a", 32'(a_req_ready), 32'(c % 2 == 0));
         check("rr_b", 32'(b_req_ready), 32'(c % 2 == 1));
         tick();
      end
`else
      a_dividend  = 10'd10;
      b_dividend  = 10'd300;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      #1;
      for (int c = 0; c < 10; c++) begin
         check("starve_b", 32'(b_req_ready), 32'(c == 4 || c == 9));
         check("starve_a", 32'(a_req_ready), 32'(!(c == 4 || c == 9)));
         tick();
      end
`endif
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      repeat (4) tick();
      check("arb_drain", sb.size(), 0);

      // backpressure on port A
      a_resp_ready = 1'b0;
      a_req_valid  = 1'b1;
      a_dividend   = 10'd101;
      #1;
      check("bp_rdy0", 32'(a_req_ready), 1);
      tick();
      a_dividend = 10'd202;
      check("bp_rdy1", 32'(a_req_ready), 1);
      tick();
      a_dividend = 10'd303;
      for (int c = 0; c < 3; c++) begin
         check("bp_rdy", 32'(a_req_ready), 0);
         check("bp_rv", 32'(a_resp_valid), 1);
         check("bp_quot", 32'(resp_quot), ref_quot(101));
         check("bp_rem", 32'(resp_rem), ref_rem(101));
         tick();
      end
      a_resp_ready = 1'b1;
      acc_a = 1'b0;
      n = 0;
      while (!acc_a && n < 10) begin
         tick();
         n++;
      end
      check("bp_acc", 32'(acc_a), 1);
      a_req_valid = 1'b0;
      repeat (5) tick();
      check("bp_drain", sb.size(), 0);

      // reset with both stages full
      a_resp_ready = 1'b0;
      a_req_valid  = 1'b1;
      a_dividend   = 10'd55;
      tick();
      a_dividend = 10'd66;
      tick();
      check("mid_pre_rv", 32'(a_resp_valid), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rv", 32'(a_resp_valid), 0);
      check("mid_rdy", 32'(a_req_ready), 0);
      check("mid_quot", 32'(resp_quot), 0);
      check("mid_rem", 32'(resp_rem), 0);
      sb.delete();
      b_wait = 0;
      last_b = 1'b1;
      a_req_valid  = 1'b0;
      a_resp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) tick();
      check("mid_stale", 32'(a_resp_valid), 0);
      a_dividend  = 10'd77;
      a_req_valid = 1'b1;
      acc_a = 1'b0;
      n = 0;
      while (!acc_a && n < 10) begin
         tick();
         n++;
      end
      check("mid_acc", 32'(acc_a), 1);
      a_req_valid = 1'b0;
      tick();
      check("mid_new_rv", 32'(a_resp_valid), 1);
      check("mid_new_quot", 32'(resp_quot), ref_quot(77));
      check("mid_new_rem", 32'(resp_rem), ref_rem(77));
      tick();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         a_req_valid = ($urandom_range(0, 9) < 7);
         b_req_valid = ($urandom_range(0, 9) < 5);
         if ($urandom_range(0, 3) == 0)
            a_dividend = DW'(20 * $urandom_range(0, 21) + $urandom_range(0, 1));
         else
            a_dividend = DW'($urandom_range(0, 1023));
         b_dividend   = DW'($urandom_range(0, 1023));
         a_resp_ready = ($urandom_range(0, 3) != 0);
         b_resp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      a_req_valid  = 1'b0;
      b_req_valid  = 1'b0;
      a_resp_ready = 1'b1;
      b_resp_ready = 1'b1;
      repeat (6) tick();
      check("final_drain", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
